// File: rtl/pixel_point_op_engine_pkg.sv
// Shared types and default sizing for the pixel point-operation engine.
package pixel_point_op_engine_pkg;

  localparam int DEF_DATA_W    = 128;
  localparam int DEF_PIX_W     = 8;
  localparam int DEF_BURST_LEN = 32;

  // Per-lane operation selected at burst start
  typedef enum logic [1:0] {
    INVERT  = 2'd0,
    THRESH  = 2'd1,
    ADD_SAT = 2'd2,
    SUB_SAT = 2'd3
  } pix_mode_e;

  // Burst sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eng_state_e;

  // Counter width able to hold the value burst_len itself
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/pixel_point_op_engine_if.sv
// Control and streaming bundle between the engine and its surroundings.
// The master side issues bursts and feeds beats; the slave side is the engine.
interface pixel_point_op_engine_if
  import pixel_point_op_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_W  = DEF_PIX_W
);

  logic              start;
  pix_mode_e         mode;
  logic [PIX_W-1:0]  operand;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, operand, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, mode, operand, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/pixel_point_op_engine_lane_op.sv
// Combinational point operation on a single unsigned pixel.
module pix_lane_op
  import pixel_point_op_engine_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  pix_mode_e        mode_i,
  input  logic [PIX_W-1:0] operand_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam logic [PIX_W-1:0] MAX_PIX = '1;

  logic [PIX_W:0] sum;

  assign sum = {1'b0, pix_i} + {1'b0, operand_i};

  // Select the lane result; add/sub clamp at the unsigned range limits
  always_comb begin
    pix_o = '0;
    case (mode_i)
      INVERT:  pix_o = MAX_PIX - pix_i;
      THRESH:  pix_o = (pix_i >= operand_i) ? MAX_PIX : '0;
      ADD_SAT: pix_o = sum[PIX_W] ? MAX_PIX : sum[PIX_W-1:0];
      SUB_SAT: pix_o = (pix_i < operand_i) ? '0 : (pix_i - operand_i);
      default: pix_o = '0;
    endcase
  end

endmodule

// File: rtl/pixel_point_op_engine.sv
// Streaming per-pixel point-operation engine: one burst of BURST_LEN beats,
// every lane transformed by the operation latched at start, two-stage
// pipeline with full valid/ready backpressure and a done pulse at the end.
module pixel_point_op_engine
  import pixel_point_op_engine_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  pixel_point_op_engine_if.slave bus
);

  localparam int LANES = DATA_W / PIX_W;
  localparam int CNT_W = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  eng_state_e        state_q, state_d;
  pix_mode_e         mode_q, mode_d;
  logic [PIX_W-1:0]  operand_q, operand_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;

  logic              busy_s, done_s;
  logic              start_acc, in_ready_s, in_fire, out_fire;
  logic              s1_adv, s2_adv;
  logic [DATA_W-1:0] lane_res;

  // A stage can take new data when it is empty or its content moves on this cycle
  assign s2_adv     = !s2_valid_q || bus.out_ready;
  assign s1_adv     = !s1_valid_q || s2_adv;
  assign in_ready_s = (state_q == RUN) && (in_cnt_q < BURST_CNT) && s1_adv;
  assign in_fire    = bus.in_valid && in_ready_s;
  assign out_fire   = s2_valid_q && bus.out_ready;
  assign start_acc  = bus.start && ((state_q == IDLE) || (state_q == DONE));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pix_lane_op #(.PIX_W(PIX_W)) u_lane (
      .mode_i    (mode_q),
      .operand_i (operand_q),
      .pix_i     (bus.in_data[i*PIX_W +: PIX_W]),
      .pix_o     (lane_res[i*PIX_W +: PIX_W])
    );
  end

  // Burst sequencing and the Moore busy/done outputs
  always_comb begin
    state_d = state_q;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) state_d = RUN;
      end
      RUN: begin
        busy_s = 1'b1;
        if (in_cnt_q == BURST_CNT) state_d = DRAIN;
      end
      DRAIN: begin
        busy_s = 1'b1;
        if (out_cnt_d == BURST_CNT) state_d = DONE;
      end
      DONE: begin
        done_s  = 1'b1;
        state_d = start_acc ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst configuration, beat counters and the two pipeline stages
  always_comb begin
    mode_d     = mode_q;
    operand_d  = operand_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    if (start_acc) begin
      mode_d    = bus.mode;
      operand_d = bus.operand;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (in_fire)  in_cnt_d  = in_cnt_q + CNT_ONE;
      if (out_fire) out_cnt_d = out_cnt_q + CNT_ONE;
    end

    if (s1_adv) begin
      s1_valid_d = in_fire;
      if (in_fire) s1_data_d = lane_res;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = s1_data_q;
    end
  end

  // State and datapath registers; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= INVERT;
      operand_q  <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      operand_q  <= operand_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;

endmodule

// File: tb/tb_pixel_point_op_engine.sv
// Randomized self-checking bench for pixel_point_op_engine. A behavioural
// lane model predicts every output beat from the accepted input beats.
module tb_pixel_point_op_engine;
  import pixel_point_op_engine_pkg::*;

  localparam int BURST = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;

  int cycle        = 0;
  int tbMode       = 0;
  int tbOp         = 0;
  int acceptCnt    = 0;
  int outCnt       = 0;
  int doneCnt      = 0;
  int lastOutCycle = -100;
  bit stallPending = 1'b0;
  logic [127:0] heldData = '0;
  logic [127:0] expQ[$];
  logic [127:0] q2[$];

  pixel_point_op_engine_if #(.DATA_W(128), .PIX_W(8))  ifc ();
  pixel_point_op_engine_if #(.DATA_W(128), .PIX_W(16)) ifc2 ();

  pixel_point_op_engine #(.DATA_W(128), .PIX_W(8), .BURST_LEN(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  pixel_point_op_engine #(.DATA_W(128), .PIX_W(16), .BURST_LEN(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifc2)
  );

  // Free-running clock and cycle index used for timing checks
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Count one comparison and report it when the observed value differs
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] randBeat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: each lane treated as an unsigned number, rules applied arithmetically
  function automatic logic [127:0] refBeat(input int md, input int op, input logic [127:0] d, input int pw);
    logic [127:0] r;
    longint maxv, p, v, o;
    r    = '0;
    maxv = (longint'(1) << pw) - 1;
    o    = longint'(op);
    for (int i = 0; i < 128 / pw; i++) begin
      p = longint'((d >> (i * pw)) & 128'(maxv));
      case (md)
        0:       v = maxv - p;
        1:       v = (p >= o) ? maxv : 0;
        2:       v = (p + o > maxv) ? maxv : p + o;
        default: v = (p < o) ? 0 : p - o;
      endcase
      r = r | (128'(v) << (i * pw));
    end
    return r;
  endfunction

  // Monitor for the 8-bit engine: scoreboard, stall stability and done timing
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      stallPending = 1'b0;
    end else begin
      if (stallPending) begin
        checkOutput("stallValid", 128'(ifc.out_valid), 128'd1);
        checkOutput("stallData", ifc.out_data, heldData);
      end
      stallPending = 1'b0;
      if (ifc.in_valid && ifc.in_ready) begin
        expQ.push_back(refBeat(tbMode, tbOp, ifc.in_data, 8));
        acceptCnt++;
      end
      if (ifc.out_valid) begin
        if (ifc.out_ready) begin
          checkOutput("beatExpected", 128'(expQ.size() != 0), 128'd1);
          if (expQ.size() != 0) checkOutput("beatData", ifc.out_data, expQ.pop_front());
          lastOutCycle = cycle;
          outCnt++;
        end else begin
          stallPending = 1'b1;
          heldData     = ifc.out_data;
        end
      end
      if (ifc.done) begin
        doneCnt++;
        checkOutput("doneTiming", 128'(cycle - lastOutCycle), 128'd1);
        checkOutput("busyInDone", 128'(ifc.busy), 128'd0);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a start pulse; called just after a rising edge
  task automatic startBurst(input int md, input int op);
    ifc.start   = 1'b1;
    ifc.mode    = pix_mode_e'(2'(md));
    ifc.operand = 8'(op);
    tbMode      = md;
    tbOp        = op;
    @(posedge clk) #1;
    ifc.start   = 1'b0;
  endtask

  // Feed one burst and drain it; returns at the cycle after the last output
  task automatic applyStimulus(input int beats, input bit holdValid, input bit randReady,
                               input logic [127:0] firstData, input bit inject, input int stopAcc,
                               output int accepted, output int latency);
    int outs, cyc, firstAcc, firstVal;
    bit needData;
    outs = 0; cyc = 0; accepted = 0; firstAcc = -1; firstVal = -1; needData = 1'b1; latency = -1;
    while (outs < BURST && cyc < 3000) begin
      ifc.in_valid = holdValid ? (cyc < beats) : (accepted < beats);
      if (needData) begin
        ifc.in_data = (accepted == 0) ? firstData : randBeat();
        needData    = 1'b0;
      end
      ifc.out_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifc.start     = inject && (cyc == 5);
      if (inject && cyc == 5) ifc.mode = pix_mode_e'(2'((tbMode + 1) % 4));
      @(negedge clk);
      if (inject && cyc == 5) checkOutput("busyIgnoredStart", 128'(ifc.busy), 128'd1);
      if (ifc.in_valid && ifc.in_ready) begin
        if (firstAcc < 0) firstAcc = cyc;
        accepted++;
        needData = 1'b1;
      end
      if (ifc.out_valid && firstVal < 0) firstVal = cyc;
      if (ifc.out_valid && ifc.out_ready) outs++;
      if (stopAcc > 0 && accepted >= stopAcc) break;
      @(posedge clk) #1;
      cyc++;
    end
    if (stopAcc == 0) begin
      ifc.in_valid = 1'b0;
      ifc.start    = 1'b0;
      checkOutput("burstComplete", 128'(outs), 128'(BURST));
    end
    if (firstAcc >= 0 && firstVal >= 0) latency = firstVal - firstAcc;
  endtask

  task automatic endOfBurst(input string tag, input int d0, input int acc);
    waitCycles(3);
    checkOutput({tag, "_doneOnce"}, 128'(doneCnt - d0), 128'd1);
    checkOutput({tag, "_accepted"}, 128'(acc), 128'(BURST));
    checkOutput({tag, "_queueEmpty"}, 128'(expQ.size()), 128'd0);
    checkOutput({tag, "_idleBusy"}, 128'(ifc.busy), 128'd0);
  endtask

  initial begin
    int acc, lat, d0, outs2, acc2, dones2, lastOut2;
    logic [127:0] d;

    ifc.start = 1'b0; ifc.mode = INVERT; ifc.operand = '0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    ifc2.start = 1'b0; ifc2.mode = INVERT; ifc2.operand = '0;
    ifc2.in_valid = 1'b0; ifc2.in_data = '0; ifc2.out_ready = 1'b1;

    // Reset state
    #12;
    checkOutput("rstInReady", 128'(ifc.in_ready), 128'd0);
    checkOutput("rstOutValid", 128'(ifc.out_valid), 128'd0);
    checkOutput("rstOutData", ifc.out_data, 128'd0);
    checkOutput("rstBusy", 128'(ifc.busy), 128'd0);
    checkOutput("rstDone", 128'(ifc.done), 128'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    waitCycles(2);
    checkOutput("idleInReady", 128'(ifc.in_ready), 128'd0);

    // Invert with the extreme pixel values, no backpressure, latency check
    d = randBeat();
    d[23:0] = 24'hFF_37_00;
    d0 = doneCnt;
    startBurst(0, 0);
    applyStimulus(BURST, 1'b0, 1'b0, d, 1'b0, 0, acc, lat);
    checkOutput("latency", 128'(lat), 128'd2);
    endOfBurst("invert", d0, acc);

    // Threshold, saturating add and saturating subtract around their limits
    d = randBeat(); d[15:0] = 16'h80_7F;
    d0 = doneCnt;
    startBurst(1, 8'h80);
    applyStimulus(BURST, 1'b0, 1'b0, d, 1'b0, 0, acc, lat);
    endOfBurst("thresh", d0, acc);

    d = randBeat(); d[15:0] = 16'h10_F0;
    d0 = doneCnt;
    startBurst(2, 8'h20);
    applyStimulus(BURST, 1'b0, 1'b0, d, 1'b0, 0, acc, lat);
    endOfBurst("addSat", d0, acc);

    d = randBeat(); d[15:0] = 16'h50_10;
    d0 = doneCnt;
    startBurst(3, 8'h20);
    applyStimulus(BURST, 1'b0, 1'b0, d, 1'b0, 0, acc, lat);
    endOfBurst("subSat", d0, acc);

    // Random operations under random output backpressure
    for (int k = 0; k < 3; k++) begin
      d0 = doneCnt;
      startBurst(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      applyStimulus(BURST, 1'b0, 1'b1, randBeat(), 1'b0, 0, acc, lat);
      endOfBurst("backpressure", d0, acc);
    end

    // Over-long input offer, ignored start while busy, back-to-back restart in done
    d0 = doneCnt;
    startBurst(1, int'($urandom_range(1, 254)));
    applyStimulus(40, 1'b1, 1'b0, randBeat(), 1'b1, 0, acc, lat);
    checkOutput("holdAccepted", 128'(acc), 128'(BURST));
    checkOutput("doneCycle", 128'(ifc.done), 128'd1);
    ifc.start   = 1'b1;
    ifc.mode    = SUB_SAT;
    ifc.operand = 8'h33;
    tbMode      = 3;
    tbOp        = 8'h33;
    @(posedge clk) #1;
    ifc.start = 1'b0;
    checkOutput("b2bBusy", 128'(ifc.busy), 128'd1);
    applyStimulus(BURST, 1'b0, 1'b1, randBeat(), 1'b0, 0, acc, lat);
    waitCycles(3);
    checkOutput("b2bDones", 128'(doneCnt - d0), 128'd2);
    checkOutput("b2bAccepted", 128'(acc), 128'(BURST));
    checkOutput("b2bQueueEmpty", 128'(expQ.size()), 128'd0);

    // Reset in the middle of a burst
    startBurst(2, int'($urandom_range(0, 255)));
    applyStimulus(BURST, 1'b0, 1'b0, randBeat(), 1'b0, 10, acc, lat);
    @(posedge clk) #1;
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    #1;
    checkOutput("midRstInReady", 128'(ifc.in_ready), 128'd0);
    checkOutput("midRstOutValid", 128'(ifc.out_valid), 128'd0);
    checkOutput("midRstOutData", ifc.out_data, 128'd0);
    checkOutput("midRstBusy", 128'(ifc.busy), 128'd0);
    checkOutput("midRstDone", 128'(ifc.done), 128'd0);
    d0 = doneCnt;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(6);
    checkOutput("noDoneAfterRst", 128'(doneCnt - d0), 128'd0);
    startBurst(0, 0);
    applyStimulus(BURST, 1'b0, 1'b1, randBeat(), 1'b0, 0, acc, lat);
    endOfBurst("afterRst", d0, acc);

    // 16-bit lanes, four-beat burst on the second engine
    ifc2.start = 1'b1; ifc2.mode = INVERT; ifc2.operand = '0;
    @(posedge clk) #1;
    ifc2.start = 1'b0;
    d = {8{16'h1234}};
    outs2 = 0; acc2 = 0; dones2 = 0; lastOut2 = -10;
    for (int cyc = 0; cyc < 200 && dones2 == 0; cyc++) begin
      ifc2.in_valid  = (acc2 < 4);
      ifc2.in_data   = (acc2 == 0) ? d : randBeat();
      ifc2.out_ready = 1'b1;
      @(negedge clk);
      if (ifc2.in_valid && ifc2.in_ready) begin
        q2.push_back(refBeat(0, 0, ifc2.in_data, 16));
        acc2++;
      end
      if (ifc2.out_valid && ifc2.out_ready) begin
        if (outs2 == 0) checkOutput("w16Lane0", 128'(ifc2.out_data[15:0]), 128'h EDCB);
        checkOutput("w16Expected", 128'(q2.size() != 0), 128'd1);
        if (q2.size() != 0) checkOutput("w16Beat", ifc2.out_data, q2.pop_front());
        outs2++;
        lastOut2 = cyc;
      end
      if (ifc2.done) begin
        dones2++;
        checkOutput("w16DoneTiming", 128'(cyc - lastOut2), 128'd1);
      end
      @(posedge clk) #1;
    end
    ifc2.in_valid = 1'b0;
    checkOutput("w16Accepted", 128'(acc2), 128'd4);
    checkOutput("w16Outputs", 128'(outs2), 128'd4);
    checkOutput("w16Dones", 128'(dones2), 128'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
